// File: rtl/mem_bus_arbiter.sv
// Arbitrates one synchronous single-port RAM between the CPU (fixed priority) and a DMA requester.
// Define ARB_BURST_LOCK_EN to let DMA hold the bus for bursts via dma_lock.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CPU  = 2'b01;
  localparam logic [1:0] ST_DMA  = 2'b10;

  if (MAX_WAIT < 1 || MAX_WAIT > 15 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
    $error("mem_bus_arbiter: MAX_WAIT or MAX_BURST out of range");
  end

  logic [3:0] wait_cnt;
  logic       starve;
  logic       lock_win;
  logic       grant_cpu;
  logic       grant_dma;

  assign starve    = (wait_cnt == 4'(MAX_WAIT));
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

`ifdef ARB_BURST_LOCK_EN
  localparam logic [2:0] ST_DMA_LOCK = {1'b1, ST_DMA};

  logic       lock_q;
  logic [7:0] burst_cnt;
  logic       burst_full;
  logic [2:0] state;

  // Full state view: owner plus the lock qualifier.
  assign state      = {lock_q, owner};
  assign burst_full = (burst_cnt == 8'(MAX_BURST));
  assign lock_win   = lock_q && dma_req && dma_lock && !(cpu_req && burst_full);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_q    <= 1'b0;
      burst_cnt <= 8'd0;
    end else if (grant_dma && dma_lock) begin
      lock_q <= 1'b1;
      if (!lock_q)
        burst_cnt <= 8'd1;
      else if (!burst_full)
        burst_cnt <= burst_cnt + 8'd1;
    end else if (grant_cpu && lock_q && dma_req && dma_lock) begin
      // CPU took its slot after a full burst; lock stays armed for the next DMA grant.
      burst_cnt <= 8'd0;
    end else if (!(dma_req && dma_lock)) begin
      lock_q    <= 1'b0;
      burst_cnt <= 8'd0;
    end
  end

  logic unused_state;
  assign unused_state = (state == ST_DMA_LOCK);
`else
  logic unused_lock;
  assign unused_lock = dma_lock;
  assign lock_win    = 1'b0;
`endif

  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (lock_win)
      grant_dma = 1'b1;
    else if (starve && dma_req)
      grant_dma = 1'b1;
    else if (cpu_req)
      grant_cpu = 1'b1;
    else if (dma_req)
      grant_dma = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      owner      <= ST_IDLE;
      wait_cnt   <= 4'd0;
    end else begin
      cpu_gnt    <= grant_cpu;
      dma_gnt    <= grant_dma;
      // mem_we still describes the access granted last cycle, so it tells reads from writes.
      cpu_rvalid <= cpu_gnt && !mem_we;
      dma_rvalid <= dma_gnt && !mem_we;
      if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
        owner     <= ST_CPU;
      end else if (grant_dma) begin
        mem_addr  <= dma_addr;
        mem_we    <= dma_we;
        mem_wdata <= dma_wdata;
        owner     <= ST_DMA;
      end else begin
        mem_we <= 1'b0;
        owner  <= ST_IDLE;
      end
      if (!dma_req || grant_dma)
        wait_cnt <= 4'd0;
      else if (!starve)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule
